// File: rtl/address_arbiter_n.sv
// Round-robin N-port address arbiter with bounded bursts and a registered address output.
// Ownership is held until last, burst cap or requester abandon; each release costs one idle cycle.
module address_arbiter_n #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_BURST  = 16,
    localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in,
    input  logic [NUM_PORTS-1:0]            last,
    input  logic                            mem_ready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [ADDR_WIDTH-1:0]           addr_out,
    output logic                            addr_valid,
    output logic [PW-1:0]                   port_out
);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q;
    logic [PW-1:0]           owner_q;
    logic [PW-1:0]           rr_ptr_q;
    logic [BW-1:0]           beats_q;
    logic [NUM_PORTS-1:0]    grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    valid_q;
    logic [PW-1:0]           port_q;

    logic                    sel_found_d;
    logic [PW-1:0]           sel_d;
    logic [NUM_PORTS-1:0]    sel_onehot_d;
    logic [PW-1:0]           rr_next_d;
    logic                    owner_req;
    logic                    owner_last;
    logic                    cap_hit;
    logic [ADDR_WIDTH-1:0]   owner_addr;
    int                      idx;

    // First requesting port at or after rr_ptr, wrapping past the top port.
    always_comb begin
        sel_found_d = 1'b0;
        sel_d       = '0;
        idx         = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (!sel_found_d && req[idx]) begin
                sel_found_d = 1'b1;
                sel_d       = PW'(idx);
            end
        end
    end

    assign sel_onehot_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << sel_d;
    assign rr_next_d    = (owner_q == PW'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
    assign owner_req    = req[owner_q];
    assign owner_last   = last[owner_q];
    assign owner_addr   = addr_in[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign cap_hit      = (beats_q == BW'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beats_q  <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            port_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_found_d) begin
                        owner_q <= sel_d;
                        grant_q <= sel_onehot_d;
                        beats_q <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_next_d;
                        state_q  <= IDLE;
                    end else if (mem_ready) begin
                        addr_q  <= owner_addr;
                        port_q  <= owner_q;
                        valid_q <= 1'b1;
                        beats_q <= beats_q + 1'b1;
                        // Final transfer and release share the same edge.
                        if (owner_last || cap_hit) begin
                            grant_q  <= '0;
                            rr_ptr_q <= rr_next_d;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant      = grant_q;
    assign addr_out   = addr_q;
    assign addr_valid = valid_q;
    assign port_out   = port_q;

endmodule

// File: tb/tb_address_arbiter_n.sv
// Directed bench for address_arbiter_n: reset, single burst, round-robin, burst cap, stall, abandon.
module tb_address_arbiter_n;
    localparam int NP = 4;
    localparam int AW = 14;
    localparam int MB = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    req;
    logic [NP*AW-1:0] addr_in;
    logic [NP-1:0]    last;
    logic             mem_ready;
    logic [NP-1:0]    grant;
    logic [AW-1:0]    addr_out;
    logic             addr_valid;
    logic [1:0]       port_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    address_arbiter_n #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req(req), .addr_in(addr_in), .last(last),
        .mem_ready(mem_ready), .grant(grant), .addr_out(addr_out),
        .addr_valid(addr_valid), .port_out(port_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        addr_in[p*AW +: AW] = a;
    endtask

    initial begin
        reset = 1'b1; req = '0; addr_in = '0; last = '0; mem_ready = 1'b1;
        for (int i = 0; i < NP; i++) set_addr(i, AW'(32'h1000 + i*16));
        tick;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(addr_valid), 0);
        chk("rst_addr", 32'(addr_out), 0);
        chk("rst_port", 32'(port_out), 0);
        reset = 1'b0;

        // Single burst on port 1
        req = 4'b0010; set_addr(1, 14'h0100);
        tick;
        chk("sb_grant", 32'(grant), 32'h2);
        chk("sb_valid0", 32'(addr_valid), 0);
        tick;
        chk("sb_v1", 32'(addr_valid), 1); chk("sb_a1", 32'(addr_out), 32'h100); chk("sb_p1", 32'(port_out), 1);
        set_addr(1, 14'h0101);
        tick;
        chk("sb_v2", 32'(addr_valid), 1); chk("sb_a2", 32'(addr_out), 32'h101);
        set_addr(1, 14'h0102); last = 4'b0010;
        tick;
        chk("sb_v3", 32'(addr_valid), 1); chk("sb_a3", 32'(addr_out), 32'h102);
        chk("sb_p3", 32'(port_out), 1); chk("sb_rel_grant", 32'(grant), 0);
        req = '0; last = '0; set_addr(1, 14'h1010);
        tick;
        chk("sb_after_valid", 32'(addr_valid), 0); chk("sb_hold_addr", 32'(addr_out), 32'h102);
        chk("sb_idle_grant", 32'(grant), 0);

        // Reset mid-burst: rr_ptr is 2, port 2 owns and issues 5 beats
        req = 4'b0100;
        tick;
        chk("rmb_grant", 32'(grant), 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rmb_beat_valid", 32'(addr_valid), 1);
        end
        chk("rmb_addr", 32'(addr_out), 32'h1020);
        reset = 1'b1; req = '1;
        tick;
        chk("rmb_grant0", 32'(grant), 0); chk("rmb_valid0", 32'(addr_valid), 0);
        chk("rmb_addr0", 32'(addr_out), 0); chk("rmb_port0", 32'(port_out), 0);
        reset = 1'b0;
        tick;
        chk("rmb_first_grant", 32'(grant), 32'h1);

        // Round-robin, bursts of 2 with last, one bubble between owners
        for (int o = 0; o < NP; o++) begin
            tick;
            chk("rr_v1", 32'(addr_valid), 1); chk("rr_p1", 32'(port_out), 32'(o));
            chk("rr_a1", 32'(addr_out), 32'h1000 + 32'(o)*16);
            last = '1;
            tick;
            chk("rr_v2", 32'(addr_valid), 1); chk("rr_bubble", 32'(grant), 0);
            last = '0;
            tick;
            chk("rr_next_grant", 32'(grant), 32'(1) << ((o + 1) % NP));
        end
        req = '0;
        tick;
        chk("rr_abandon_valid", 32'(addr_valid), 0); chk("rr_abandon_grant", 32'(grant), 0);

        // Burst cap: port 3 holds req with last low
        req = 4'b1000;
        tick;
        chk("cap_grant", 32'(grant), 32'h8);
        req = '1; cnt = 0;
        for (int i = 0; i < MB; i++) begin
            tick;
            if (addr_valid && port_out == 2'd3) cnt++;
        end
        chk("cap_count", 32'(cnt), 32'(MB)); chk("cap_release", 32'(grant), 0);
        tick;
        chk("cap_next0", 32'(grant), 32'h1);
        last = '1;
        for (int o = 0; o < 3; o++) begin
            tick;
            chk("cap_serve_valid", 32'(addr_valid), 1); chk("cap_serve_port", 32'(port_out), 32'(o));
            chk("cap_serve_rel", 32'(grant), 0);
            tick;
            chk("cap_order", 32'(grant), 32'(1) << (o + 1));
        end
        tick;
        chk("cap_p3_valid", 32'(addr_valid), 1); chk("cap_p3_port", 32'(port_out), 3);

        // Stall on port 0 after one beat
        req = 4'b0001; last = '0;
        tick;
        chk("st_grant", 32'(grant), 32'h1);
        tick;
        chk("st_v1", 32'(addr_valid), 1); chk("st_a1", 32'(addr_out), 32'h1000);
        set_addr(0, 14'h0AAA); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("st_valid", 32'(addr_valid), 0); chk("st_addr_hold", 32'(addr_out), 32'h1000);
            chk("st_grant_hold", 32'(grant), 32'h1);
        end
        mem_ready = 1'b1; cnt = 0;
        for (int i = 0; i < MB - 1; i++) begin
            tick;
            if (addr_valid) cnt++;
        end
        chk("st_rest_count", 32'(cnt), 32'(MB - 1)); chk("st_release", 32'(grant), 0);
        chk("st_new_addr", 32'(addr_out), 32'h0AAA);

        // Abandon: port 2 drops after one transfer, next grant wraps to port 0
        set_addr(2, 14'h2222); req = 4'b0100;
        tick;
        chk("ab_grant", 32'(grant), 32'h4);
        tick;
        chk("ab_v1", 32'(addr_valid), 1); chk("ab_a1", 32'(addr_out), 32'h2222);
        chk("ab_p1", 32'(port_out), 2);
        req = 4'b0001;
        tick;
        chk("ab_valid", 32'(addr_valid), 0); chk("ab_rel", 32'(grant), 0);
        tick;
        chk("ab_wrap_grant", 32'(grant), 32'h1);
        req = '0; last = '1;
        tick;
        chk("ab_last_drop_valid", 32'(addr_valid), 0); chk("ab_last_drop_rel", 32'(grant), 0);
        chk("ab_addr_hold", 32'(addr_out), 32'h2222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
